cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control unit for the 16-bit simple CPU datapath. It sequences fetch, decode and execute of 32-bit instructions, drives every datapath control strobe, and latches the comparison flags used by conditional branches. It is the only driver of the datapath control inputs and sits beside the datapath in the CPU top level.

## Interface
Parameters: none; all encodings come from `cpu_pkg`.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- run  in  1  level; allows leaving IDLE and starting the next instruction
- opcode_in  in  4  IR[31:28] from the datapath
- rd_addr_in  in  3  IR[27:25] (Rx/Rd) from the datapath
- zero_flag_in  in  1  ALU zero, combinational from the datapath
- negative_flag_in  in  1  ALU negative, combinational from the datapath
- pc_write_enable  out  1  PC load strobe
- pc_source_sel  out  2  PC mux select: 00 PC+1, 01 branch, 10 LR (R7), 11 call
- ir_write_enable  out  1  IR load strobe
- rf_write_enable  out  1  register-file write strobe
- rf_write_dest_sel_addr  out  3  write address
- rf_write_data_sel  out  2  write-data mux select: 00 ALU, 01 imm16, 10 PC
- alu_op_sel  out  3  ALU operation
- alu_b_src_sel  out  1  ALU B input: 0 Ry, 1 imm16
- z_flag, n_flag  out  1 each  latched compare flags
- halted  out  1  high in HALT
- illegal_op  out  1  sticky; set on a reserved opcode
- instr_retired  out  1  one-cycle pulse on the final execute cycle of each instruction
- state_out  out  3  current state encoding (debug)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, RET2, HALT.
- Transitions:
  - IDLE→FETCH when run=1.
  - FETCH→DECODE.
  - DECODE→EXEC.
  - EXEC→RET2 if opcode is RET; otherwise →HALT if opcode is HALT; otherwise →FETCH if run=1, else →IDLE.
  - RET2→FETCH if run=1, else →IDLE.
  - HALT is absorbing; only reset leaves it.
- FETCH: ir_write_enable=1.
- DECODE: all strobes 0.
- Per-opcode behaviour. All are single-cycle in EXEC unless noted; "PC+1" means pc_write_enable=1 with sel 00.
  - 0 NOP: PC+1.
  - 1 LOAD: Rx←imm16; wdata_sel 01; PC+1.
  - 2 MOV: Rx←Ry; ALU PASS_B, b_src 0; PC+1.
  - 3 ADD: Rx←Rx+Ry; PC+1.
  - 4 ADDI: Rx←Rx+imm16; b_src 1; PC+1.
  - 5 XOR: Rx←Rx^Ry; PC+1.
  - 6 CMP: ALU SUB with b_src 0, no RF write; z_flag←zero_flag_in and n_flag←negative_flag_in at the EXEC edge; PC+1.
  - 7 BR: PC←PC+imm16 (sel 01).
  - 8 BEQ: taken if z_flag.
  - 9 BNE: taken if !z_flag.
  - A BLT: taken if n_flag.
  - For 8–A: taken → sel 01; not taken → sel 00.
  - B CALL: rf_write_enable=1, dest 3'b111, wdata_sel 10, pc_source_sel 11. In the same edge, LR receives the CALL address and PC receives the target.
  - C RET, two cycles: EXEC sets PC←R7 (sel 10); RET2 sets PC←PC+1. The net effect resumes at CALL+1.
  - D, E reserved: behave as NOP and set illegal_op.
  - F HALT: no PC write; enter HALT.
- Outside EXEC/RET2, all enables are 0, selects are 0, and alu_op_sel is ADD.
- Only CMP updates z_flag/n_flag. Branch offsets are signed 16-bit; PC wraps modulo 2^16.

## Timing
- Reset value of every output is 0. The state resets to IDLE and z_flag, n_flag and illegal_op clear.
- Reset asserted mid-instruction aborts immediately; no partial PC or RF write completes after reset assertion.
- Latency from entering FETCH to instruction_retired: 3 cycles, or 4 for RET. The pulse occurs in EXEC, or in RET2 for RET.
- run is sampled only in IDLE, at the end of EXEC and in RET2. Deasserting run mid-instruction completes that instruction before entering IDLE.
- A CMP immediately followed by a branch uses the new flags, because the flags latch at the CMP EXEC edge.
- IR resets to 0, so the opcode is NOP until the first FETCH.

## Structure
- `cpu_pkg` holds:
  - opcode localparams (OP_NOP…OP_HALT);
  - ALU op codes: ADD 000, SUB 001, XOR 010, PASS_B 011;
  - PC select and write-data select codes;
  - LR_ADDR = 3'b111;
  - the state enum.
- One natural sub-module: `cpu_decode`, a combinational opcode→control-word table. The FSM gates that control word by state.

## Test plan
- Reset with run=0 → stays IDLE; all outputs 0 for 10 cycles.
- Program LOAD R1,5; LOAD R2,5; CMP R1,R2; BEQ +2 → z_flag=1, branch taken, PC advances by 2; instr_retired pulses every 3 cycles.
- CALL +4 at PC 3, then RET at PC 7 → R7=3 after CALL; PC=7, then 3, then 4 across EXEC/RET2; instr_retired pulses once for RET.
- ADD R1,R2 producing 0xFFFF+1 → R1=0x0000; z_flag unchanged, since only CMP updates flags.
- Opcode D → illegal_op=1 and sticky, PC+1; HALT → halted=1 and no further ir_write_enable even with run=1.
- run dropped during DECODE of ADD → ADD completes, then IDLE; reset_n pulsed during EXEC → rf_write_enable never asserted after the reset edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multi-cycle CPU control unit
package cpu_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4, OP_XOR = 4'h5, OP_CMP = 4'h6, OP_BR = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8, OP_BNE = 4'h9, OP_BLT = 4'hA, OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET = 4'hC, OP_RSVD_D = 4'hD, OP_RSVD_E = 4'hE, OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_XOR = 3'b010, ALU_PASS_B = 3'b011;
  localparam logic [1:0] PC_INC = 2'b00, PC_BR = 2'b01, PC_LR = 2'b10, PC_CALL = 2'b11;
  localparam logic [1:0] WD_ALU = 2'b00, WD_IMM = 2'b01, WD_PC = 2'b10;
  localparam logic [2:0] LR_ADDR = 3'b111;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3, S_RET2 = 3'd4, S_HALT = 3'd5
  } state_t;
  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       dest_lr;
    logic [1:0] wd_sel;
    logic [2:0] alu_op;
    logic       b_src;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: opcode to EXEC-cycle control word, branch resolution from latched flags
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       z_flag,
  input  logic       n_flag,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.pc_we = (opcode != OP_HALT);
    case (opcode)
      OP_LOAD: begin ctrl.rf_we = 1'b1; ctrl.wd_sel = WD_IMM; end
      OP_MOV: begin ctrl.rf_we = 1'b1; ctrl.alu_op = ALU_PASS_B; end
      OP_ADD: ctrl.rf_we = 1'b1;
      OP_ADDI: begin ctrl.rf_we = 1'b1; ctrl.b_src = 1'b1; end
      OP_XOR: begin ctrl.rf_we = 1'b1; ctrl.alu_op = ALU_XOR; end
      OP_CMP: ctrl.alu_op = ALU_SUB;
      OP_BR: ctrl.pc_sel = PC_BR;
      OP_BEQ: ctrl.pc_sel = z_flag ? PC_BR : PC_INC;
      OP_BNE: ctrl.pc_sel = z_flag ? PC_INC : PC_BR;
      OP_BLT: ctrl.pc_sel = n_flag ? PC_BR : PC_INC;
      OP_CALL: begin ctrl.rf_we = 1'b1; ctrl.dest_lr = 1'b1; ctrl.wd_sel = WD_PC; ctrl.pc_sel = PC_CALL; end
      OP_RET: ctrl.pc_sel = PC_LR;
      OP_RSVD_D, OP_RSVD_E: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute FSM driving the datapath strobes and compare flags
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [3:0] opcode_in,
  input  logic [2:0] rd_addr_in,
  input  logic       zero_flag_in,
  input  logic       negative_flag_in,
  output logic       pc_write_enable,
  output logic [1:0] pc_source_sel,
  output logic       ir_write_enable,
  output logic       rf_write_enable,
  output logic [2:0] rf_write_dest_sel_addr,
  output logic [1:0] rf_write_data_sel,
  output logic [2:0] alu_op_sel,
  output logic       alu_b_src_sel,
  output logic       z_flag,
  output logic       n_flag,
  output logic       halted,
  output logic       illegal_op,
  output logic       instr_retired,
  output logic [2:0] state_out
);
  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   exec, ret2;

  cpu_decode u_decode (.opcode(opcode_in), .z_flag(z_flag), .n_flag(n_flag), .ctrl(ctrl));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: state_nxt = (opcode_in == OP_RET) ? S_RET2 : (opcode_in == OP_HALT) ? S_HALT : run ? S_FETCH : S_IDLE;
      S_RET2: state_nxt = run ? S_FETCH : S_IDLE;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (exec && opcode_in == OP_CMP) begin
        z_flag <= zero_flag_in;
        n_flag <= negative_flag_in;
      end
      if (exec && ctrl.illegal) illegal_op <= 1'b1;
    end

  // The decoded control word only reaches the datapath during EXEC; RET2 finishes RET with PC+1.
  assign exec = (state == S_EXEC);
  assign ret2 = (state == S_RET2);
  assign pc_write_enable = (exec && ctrl.pc_we) || ret2;
  assign pc_source_sel = exec ? ctrl.pc_sel : PC_INC;
  assign ir_write_enable = (state == S_FETCH);
  assign rf_write_enable = exec && ctrl.rf_we;
  assign rf_write_dest_sel_addr = !rf_write_enable ? 3'd0 : ctrl.dest_lr ? LR_ADDR : rd_addr_in;
  assign rf_write_data_sel = exec ? ctrl.wd_sel : WD_ALU;
  assign alu_op_sel = exec ? ctrl.alu_op : ALU_ADD;
  assign alu_b_src_sel = exec && ctrl.b_src;
  assign halted = (state == S_HALT);
  assign instr_retired = (exec && opcode_in != OP_RET) || ret2;
  assign state_out = state;
endmodule
